audio_stream_ctrl: RTL
======================

Name: audio_stream_ctrl

Overview:
Sequences the audio codec datapath between two sources: live ADC passthrough and ROM tone playback. Owns the codec read/write handshake, the ROM address counter and the ROM read-latency wait. Supports play/pause, rewind, one-shot or looped playback, and a done pulse. Sits between the user controls and the audio_codec/ROM instances in the top level.

Parameters:
DATA_W, 24, sample width per channel
ADDR_W, 18, ROM address width
ROM_DEPTH, 48000, number of valid ROM words; last address is ROM_DEPTH-1, and ROM_DEPTH must be ≤ 2**ADDR_W
ROM_LAT, 2, clock cycles from rom_address change to valid rom_q (≥1)

Ports:
CLOCK_50  in  1  system clock, all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset (KEY[0] level)
play  in  1  level; 1 = run the selected source, 0 = pause/stop
src_sel  in  1  0 = ADC passthrough, 1 = ROM playback
loop_en  in  1  1 = wrap at end of ROM, 0 = one-shot
rewind  in  1  single-cycle pulse; returns ROM address to 0
read_ready  in  1  codec ADC FIFO has a sample
write_ready  in  1  codec DAC FIFO has space
readdata_left  in  DATA_W  ADC left sample
readdata_right  in  DATA_W  ADC right sample
rom_q  in  DATA_W  ROM output word
rom_address  out  ADDR_W  ROM address (registered)
read  out  1  codec read strobe
write  out  1  codec write strobe
writedata_left  out  DATA_W  DAC left sample
writedata_right  out  DATA_W  DAC right sample
busy  out  1  1 in any state other than IDLE and STOP
done  out  1  one-cycle pulse at end of a one-shot playback

Behaviour:
- Reset (async, reset_n=0): state IDLE, rom_address=0, sample register=0, latency counter=0, done=0. read, write, writedata_* = 0 and busy = 0 while in reset.
- States: IDLE, PASS, FETCH, HOLD, STOP.
- IDLE: read=write=0, writedata=0. If play=1 and src_sel=0, go to PASS. If play=1 and src_sel=1, go to FETCH and load the latency counter with ROM_LAT.
- PASS: read = write = read_ready & write_ready (combinational). writedata_left/right = readdata_left/right (combinational). A transfer completes in the same cycle; there is no added latency. If play=0 or src_sel=1, go to IDLE next cycle; read and write are forced to 0 in that cycle.
- FETCH: rom_address is held. The counter decrements each cycle. When it reaches 1, latch rom_q into the sample register and go to HOLD. FETCH therefore lasts exactly ROM_LAT cycles.
- HOLD: writedata_left = writedata_right = sample register. write = write_ready (combinational). On a cycle with write=1:
  - address < ROM_DEPTH-1: address+1, go to FETCH.
  - address = ROM_DEPTH-1 and loop_en=1: address=0, go to FETCH.
  - address = ROM_DEPTH-1 and loop_en=0: go to STOP; done=1 for the next cycle only.
- ROM modes (FETCH, HOLD, STOP): read = read_ready, so ADC samples are drained and discarded and the codec FIFO cannot overflow.
- STOP: write=0, writedata=0. Leave to IDLE when play=0; rom_address is cleared to 0 on that exit.
- Pause: play=0 in FETCH or HOLD goes to IDLE with rom_address retained. Playback resumes at the same address and re-fetches it.
- src_sel changes in FETCH or HOLD are ignored until the block returns to IDLE.
- rewind: accepted in any state. rom_address becomes 0 next cycle. In FETCH the latency counter reloads to ROM_LAT. Rewind has priority over the increment and wrap on a simultaneous write; that write still completes with the old sample.
- Address arithmetic: unsigned, ADDR_W bits. It never exceeds ROM_DEPTH-1, and wrap is explicit, not modular.
- Throughput: one ROM sample per write slot. Codec slots (~1041 cycles at 48 kHz) far exceed ROM_LAT+1, so write_ready is never missed.

Decomposition:
- Shared package audio_pkg: state enum (IDLE, PASS, FETCH, HOLD, STOP), DATA_W default, ROM_DEPTH default.
- One sub-module, rom_addr_gen:
  - registered address with inc, rewind and clear inputs;
  - wrap-at-ROM_DEPTH-1 logic;
  - `last` flag output.
- The FSM, latency counter and output muxing stay in audio_stream_ctrl.

Test Plan:
- Reset: reset_n=0 mid-HOLD at address 100 -> all outputs 0 and rom_address=0 immediately, without waiting for a clock edge.
- Passthrough: src_sel=0, play=1, read_ready=write_ready=1, readdata_left=24'h123456 -> read=write=1 that cycle and writedata_left=24'h123456. With write_ready=0 -> read=write=0.
- ROM timing: src_sel=1, ROM_LAT=2, ROM model returns address+24'h10, write_ready held 1 -> write pulses at addresses 0,1,2 with data 24'h10, 24'h11, 24'h12, one write every 3 cycles.
- End of ROM: ROM_DEPTH=4, loop_en=0 -> exactly 4 writes, then done=1 for one cycle, busy=0, STOP holds. play=0 -> IDLE and rom_address=0. With loop_en=1 -> address sequence 0,1,2,3,0,1.
- Pause/rewind: play drops in HOLD at address 5 -> IDLE with address 5; play=1 -> first write is address 5 again. rewind coinciding with the write at address 7 -> that write carries sample 7 and the next fetch is address 0.
- Drain: in HOLD with write_ready=0 and read_ready pulsing -> read follows read_ready and write stays 0.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding and default geometry for the audio stream controller.
package audio_pkg;
    typedef enum logic [2:0] {IDLE, PASS, FETCH, HOLD, STOP} state_t;
    localparam int DATA_W_DEF    = 24;
    localparam int ADDR_W_DEF    = 18;
    localparam int ROM_DEPTH_DEF = 48000;
    localparam int ROM_LAT_DEF   = 2;
endpackage

// File: rtl/rom_addr_gen.sv
// rom_addr_gen: registered ROM address with rewind/clear to zero and explicit wrap at the last word.
module rom_addr_gen
    import audio_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ROM_DEPTH = ROM_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              rewind_i,
    input  logic              clear_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROM_DEPTH - 1);
    logic [ADDR_W-1:0] addr_q, addr_d;
    assign addr_o = addr_q;
    assign last_o = addr_q == LAST;
    always_comb addr_d = (rewind_i | clear_i) ? '0 : inc_i ? (last_o ? '0 : addr_q + 1'b1) : addr_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) addr_q <= '0;
        else         addr_q <= addr_d;
endmodule

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: sequences codec traffic between ADC passthrough and ROM playback,
// owning the codec handshake, ROM address and ROM read-latency wait.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ROM_DEPTH = ROM_DEPTH_DEF,
    parameter int ROM_LAT   = ROM_LAT_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              play,
    input  logic              src_sel,
    input  logic              loop_en,
    input  logic              rewind,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] rom_address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(ROM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(ROM_LAT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              done_q, done_d;
    logic              inc, clear, last;

    rom_addr_gen #(.ADDR_W(ADDR_W), .ROM_DEPTH(ROM_DEPTH)) u_addr (
        .clk_i   (CLOCK_50),
        .rst_ni  (reset_n),
        .inc_i   (inc),
        .rewind_i(rewind),
        .clear_i (clear),
        .addr_o  (rom_address),
        .last_o  (last)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        sample_d        = sample_q;
        done_d          = 1'b0;
        inc             = 1'b0;
        clear           = 1'b0;
        read            = 1'b0;
        write           = 1'b0;
        writedata_left  = '0;
        writedata_right = '0;
        case (state_q)
            IDLE: if (play) begin
                state_d = src_sel ? FETCH : PASS;
                cnt_d   = LAT;
            end
            PASS: begin
                writedata_left  = readdata_left;
                writedata_right = readdata_right;
                if (!play || src_sel) state_d = IDLE;
                else begin
                    read  = read_ready & write_ready;
                    write = read_ready & write_ready;
                end
            end
            FETCH: begin
                read = read_ready;
                if (!play) state_d = IDLE;
                else if (rewind) cnt_d = LAT;
                else if (cnt_q == ONE) begin
                    sample_d = rom_q;
                    state_d  = HOLD;
                end else cnt_d = cnt_q - ONE;
            end
            HOLD: begin
                read            = read_ready;
                writedata_left  = sample_q;
                writedata_right = sample_q;
                if (!play) state_d = IDLE;
                else begin
                    write = write_ready;
                    // a rewind re-fetches word 0 rather than keeping a now-stale sample
                    if (rewind) begin
                        state_d = FETCH;
                        cnt_d   = LAT;
                    end else if (write_ready) begin
                        if (last && !loop_en) begin
                            state_d = STOP;
                            done_d  = 1'b1;
                        end else begin
                            inc     = 1'b1;
                            state_d = FETCH;
                            cnt_d   = LAT;
                        end
                    end
                end
            end
            STOP: begin
                read = read_ready;
                if (!play) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE) && (state_q != STOP);
    assign done = done_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
endmodule
